// File: rtl/alu_exec_stage.sv
// Two-stage elastic execute ALU: operand register (S1) feeding a result register (S2),
// with valid/ready on both sides, synchronous flush and a saturating retired-op counter.
module alu_exec_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [3:0] FN_AND  = 4'b0000;
  localparam logic [3:0] FN_OR   = 4'b0001;
  localparam logic [3:0] FN_XOR  = 4'b0010;
  localparam logic [3:0] FN_XNOR = 4'b0011;
  localparam logic [3:0] FN_ADD  = 4'b0100;
  localparam logic [3:0] FN_SUB  = 4'b1100;
  localparam logic [3:0] FN_SLT  = 4'b1101;

  logic              s1_valid;
  logic [3:0]        s1_func;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_load;
  logic              accept;
  logic              out_hs;

  logic [DATA_W-1:0] sum_c;
  logic [DATA_W-1:0] diff_c;
  logic [DATA_W-1:0] res_c;
  logic              lt_c;
  logic              ovf_c;
  logic              ill_c;

  // S1 advances into S2 when S2 is empty or draining this cycle
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !flush && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // ALU on the S1 operands; unknown codes fall to the illegal default
  always_comb begin
    sum_c  = s1_a + s1_b;
    diff_c = s1_a - s1_b;
    lt_c   = $signed(s1_a) < $signed(s1_b);
    res_c  = '0;
    ovf_c  = 1'b0;
    ill_c  = 1'b0;
    case (s1_func)
      FN_AND:  res_c = s1_a & s1_b;
      FN_OR:   res_c = s1_a | s1_b;
      FN_XOR:  res_c = s1_a ^ s1_b;
      FN_XNOR: res_c = ~(s1_a ^ s1_b);
      FN_ADD: begin
        res_c = sum_c;
        ovf_c = (s1_a[MSB] == s1_b[MSB]) && (sum_c[MSB] != s1_a[MSB]);
      end
      FN_SUB: begin
        res_c = diff_c;
        ovf_c = (s1_a[MSB] != s1_b[MSB]) && (diff_c[MSB] != s1_a[MSB]);
      end
      FN_SLT:  res_c = DATA_W'(lt_c);
      default: ill_c = 1'b1;
    endcase
  end

  // S1 operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_func  <= 4'b0000;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_func  <= in_func;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_tag   <= in_tag;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 result register; payload holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= 1'b1;
      out_result  <= res_c;
      out_zero    <= (res_c == '0);
      out_ovf     <= ovf_c;
      out_illegal <= ill_c;
      out_tag     <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Retired legal-op counter; a handshake in a flush cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_hs && !out_illegal && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
